// File: rtl/dcm_prog_ctrl.sv
// Front-panel controller for the dcm clock divider programming port.
// Ports: clock, reset (async high), btn_up/btn_down/btn_apply (raw),
//   prog_fb[2:0] readback in; prog_out[2:0], update, pending[2:0],
//   busy, error out. Optional macro: PROG_AUTO_APPLY_EN makes up/down
//   presses in IDLE or ERR start a send of the new selection.
module dcm_prog_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int ACK_TIMEOUT     = 4,
  parameter int MAX_RETRY       = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_apply,
  input  logic [2:0] prog_fb,
  output logic [2:0] prog_out,
  output logic       update,
  output logic [2:0] pending,
  output logic       busy,
  output logic       error
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [2:0]    raw;
  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [2:0]    deb;
  logic [2:0]    press;
  logic [CW-1:0] dcnt [3];

  logic [1:0]    state;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] retry;

  logic          up_p;
  logic          dn_p;
  logic          start;

  // bit 0 up, bit 1 down, bit 2 apply
  assign raw = {btn_apply, btn_down, btn_up};

  // press fires on the same edge the debounced level rises
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (s2[i] != deb[i]) begin
          if (dcnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i]   <= s2[i];
            dcnt[i]  <= '0;
            press[i] <= s2[i];
          end else begin
            dcnt[i] <= dcnt[i] + 1'b1;
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  assign up_p = press[0] & ~press[1];
  assign dn_p = press[1] & ~press[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else if (up_p) begin
      pending <= pending + 3'd1;
    end else if (dn_p) begin
      pending <= pending - 3'd1;
    end
  end

`ifdef PROG_AUTO_APPLY_EN
  logic auto_go;

  // one cycle late so the send latches the already-updated pending
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      auto_go <= 1'b0;
    end else begin
      auto_go <= (up_p | dn_p) &
                 ((state == S_IDLE) | (state == S_ERR));
    end
  end

  assign start = press[2] | auto_go;
`else
  assign start = press[2];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      prog_out <= '0;
      tcnt     <= '0;
      retry    <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            prog_out <= pending;
            retry    <= '0;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // a match wins over a timeout in the same cycle
          if (prog_fb == prog_out) begin
            state <= S_IDLE;
          end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
            if (retry < RW'(MAX_RETRY)) begin
              retry <= retry + 1'b1;
              state <= S_SEND;
            end else begin
              state <= S_ERR;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // decoded from state so update drops with the async reset
  assign update = (state == S_SEND);
  assign busy   = (state == S_SEND) | (state == S_WAIT);
  assign error  = (state == S_ERR);

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Directed bench for dcm_prog_ctrl with a small dcm readback model.
// Ports: none; drives DEBOUNCE_CYCLES=4, ACK_TIMEOUT=4, MAX_RETRY=2.
module tb_dcm_prog_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_up;
  logic       btn_down;
  logic       btn_apply;
  logic [2:0] prog_fb;
  logic [2:0] prog_out;
  logic       update;
  logic [2:0] pending;
  logic       busy;
  logic       error;

  logic [2:0] dcm_q;
  logic       stuck;
  int         cyc;
  int         ucnt;
  int         ut [$];
  int         total;
  int         passed;
  int         n0;
  int         exp_u;

  dcm_prog_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .ACK_TIMEOUT(4),
    .MAX_RETRY(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_apply(btn_apply),
    .prog_fb(prog_fb),
    .prog_out(prog_out),
    .update(update),
    .pending(pending),
    .busy(busy),
    .error(error)
  );

  always #5 clock = ~clock;

  // dcm captures prog_in on the update edge
  always @(posedge clock or posedge reset) begin
    if (reset) dcm_q <= '0;
    else if (update) dcm_q <= prog_out;
  end

  assign prog_fb = stuck ? 3'd0 : dcm_q;

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (update === 1'b1) begin
      ucnt = ucnt + 1;
      ut.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic press(input int idx);
    if (idx == 0) btn_up = 1'b1;
    else if (idx == 1) btn_down = 1'b1;
    else btn_apply = 1'b1;
    repeat (8) @(negedge clock);
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_apply = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic wait_upd(input string tag, input int n);
    int k;
    k = 0;
    while (update !== 1'b1 && k < n) begin
      @(negedge clock);
      k++;
    end
    chk(tag, int'(update === 1'b1), 1);
  endtask

  initial begin
    cyc = 0; ucnt = 0; total = 0; passed = 0;
    reset = 1'b1; stuck = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_apply = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_prog_out", prog_out, 0);
    chk("rst_update", update, 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    @(negedge clock);

    // held press, then a short glitch
    btn_up = 1'b1;
    repeat (10) @(negedge clock);
    btn_up = 1'b0;
    repeat (8) @(negedge clock);
    chk("up_once", pending, 1);
    btn_up = 1'b1;
    repeat (2) @(negedge clock);
    btn_up = 1'b0;
    repeat (8) @(negedge clock);
    chk("glitch", pending, 1);
`ifndef PROG_AUTO_APPLY_EN
    chk("no_upd_yet", ucnt, 0);
`endif

    // apply 5 and confirm
    repeat (4) press(0);
    chk("pend5", pending, 5);
    btn_apply = 1'b1;
    wait_upd("apply_upd", 20);
    chk("send_code", prog_out, 5);
    chk("send_busy", busy, 1);
    @(negedge clock);
    chk("upd_1cyc", update, 0);
    chk("wait_busy", busy, 1);
    @(negedge clock);
    chk("ack_busy", busy, 0);
    chk("ack_error", error, 0);
    chk("ack_fb", prog_fb, 5);
    btn_apply = 1'b0;
    repeat (8) @(negedge clock);

    // wrap both ways, simultaneous press
    repeat (2) press(0);
    chk("pend7", pending, 7);
    press(0);
    chk("wrap_up", pending, 0);
    press(1);
    chk("wrap_dn", pending, 7);
    btn_up = 1'b1;
    btn_down = 1'b1;
    repeat (8) @(negedge clock);
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (8) @(negedge clock);
    chk("both", pending, 7);

    // stuck readback: three sends then ERR
    repeat (4) press(1);
    chk("pend3", pending, 3);
    stuck = 1'b1;
    n0 = ucnt;
    btn_apply = 1'b1;
    repeat (30) @(negedge clock);
    btn_apply = 1'b0;
    repeat (8) @(negedge clock);
    chk("retry_cnt", ucnt - n0, 3);
    if (ucnt - n0 >= 3) begin
      chk("space1", ut[n0 + 1] - ut[n0], 5);
      chk("space2", ut[n0 + 2] - ut[n0 + 1], 5);
    end
    chk("err_set", error, 1);
    chk("err_busy", busy, 0);
    stuck = 1'b0;
    btn_apply = 1'b1;
    wait_upd("err_upd", 20);
    chk("err_clr", error, 0);
    repeat (2) @(negedge clock);
    chk("rec_busy", busy, 0);
    chk("rec_fb", prog_fb, 3);
    btn_apply = 1'b0;
    repeat (8) @(negedge clock);

    // apply during WAIT_ACK is dropped
    stuck = 1'b1;
    n0 = ucnt;
    btn_apply = 1'b1;
    wait_upd("ign_upd", 20);
    btn_apply = 1'b0;
    repeat (6) @(negedge clock);
    btn_apply = 1'b1;
    repeat (12) @(negedge clock);
    btn_apply = 1'b0;
    repeat (8) @(negedge clock);
    chk("ign_cnt", ucnt - n0, 3);
    chk("ign_err", error, 1);

    // reset in WAIT_ACK
    btn_apply = 1'b1;
    wait_upd("rst_upd", 20);
    @(negedge clock);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_update", update, 0);
    chk("mid_busy", busy, 0);
    chk("mid_error", error, 0);
    chk("mid_prog", prog_out, 0);
    chk("mid_pend", pending, 0);
    btn_apply = 1'b0;
    stuck = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);

    // up press alone
    n0 = ucnt;
    press(0);
    repeat (10) @(negedge clock);
`ifdef PROG_AUTO_APPLY_EN
    exp_u = 1;
    chk("auto_code", prog_out, 1);
`else
    exp_u = 0;
`endif
    chk("auto_upd", ucnt - n0, exp_u);
    chk("auto_pend", pending, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
